// File: rtl/pwr_domain_responder.sv
// Responder end of the power-request handshake: sequences clock gate, isolation, retention and power switch.
// Optional power-switch wait timeout is enabled by defining PWR_DOMAIN_RESPONDER_TIMEOUT_EN.
module pwr_domain_responder #(
    parameter int SAVE_CYCLES    = 4,
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic       req_off,
    output logic       req_ready,
    output logic       ack_valid,
    output logic       ack_err,
    input  logic       pwr_good,
    output logic       clk_en,
    output logic       iso_en,
    output logic       ret_save,
    output logic       ret_restore,
    output logic       pwr_sw_en,
    output logic [3:0] state_o,
    output logic       busy
);

    typedef enum logic [3:0] {
        ST_ON      = 4'd0,
        ST_CLK_OFF = 4'd1,
        ST_ISO     = 4'd2,
        ST_SAVE    = 4'd3,
        ST_PSW_OFF = 4'd4,
        ST_OFF     = 4'd5,
        ST_PSW_ON  = 4'd6,
        ST_SETTLE  = 4'd7,
        ST_RESTORE = 4'd8,
        ST_DEISO   = 4'd9,
        ST_CLK_ON  = 4'd10
    } state_t;

    localparam logic [7:0] SAVE_LOAD   = 8'(SAVE_CYCLES - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state_r, state_nx;
    logic [7:0] cnt_r, cnt_nx;
    logic       pg_meta_r, pg_sync_r;
    logic       accept_s, tmo_hit_s, tmo_err_s;
    logic       ack_nx, ack_err_nx;
    logic       clk_en_nx, iso_en_nx, ret_save_nx, ret_restore_nx, pwr_sw_en_nx, busy_nx, req_ready_nx;

    assign accept_s = req_valid && req_ready;
    assign state_o  = state_r;

`ifdef PWR_DOMAIN_RESPONDER_TIMEOUT_EN
    localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_r, tmo_nx;
    logic        tmo_err_r;

    // Timeout counter reloads outside the switch-wait states and counts down inside them.
    always_comb begin
        tmo_nx = tmo_r;
        if (state_r == ST_PSW_OFF || state_r == ST_PSW_ON) begin
            if (tmo_r != 16'd0) begin
                tmo_nx = tmo_r - 16'd1;
            end else begin
                tmo_nx = tmo_r;
            end
        end else begin
            tmo_nx = TMO_LOAD;
        end
    end

    // Timeout counter and sticky power-up timeout flag reported on the final ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_r     <= 16'd0;
            tmo_err_r <= 1'b0;
        end else begin
            tmo_r <= tmo_nx;
            if (state_r == ST_PSW_ON && !pg_sync_r && tmo_hit_s) begin
                tmo_err_r <= 1'b1;
            end else if (state_r == ST_OFF) begin
                tmo_err_r <= 1'b0;
            end else begin
                tmo_err_r <= tmo_err_r;
            end
        end
    end

    assign tmo_hit_s = (tmo_r == 16'd0);
    assign tmo_err_s = tmo_err_r;
`else
    // Legal TIMEOUT_CYCLES is never 0, so the timeout path folds away entirely.
    assign tmo_hit_s = (TIMEOUT_CYCLES == 0);
    assign tmo_err_s = 1'b0;
`endif

    // State register, step counter and pwr_good synchroniser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_ON;
            cnt_r     <= 8'd0;
            pg_meta_r <= 1'b1;
            pg_sync_r <= 1'b1;
        end else begin
            state_r   <= state_nx;
            cnt_r     <= cnt_nx;
            pg_meta_r <= pwr_good;
            pg_sync_r <= pg_meta_r;
        end
    end

    // Next-state, counter load and acknowledge generation.
    always_comb begin
        state_nx   = state_r;
        cnt_nx     = cnt_r;
        ack_nx     = 1'b0;
        ack_err_nx = 1'b0;
        case (state_r)
            ST_ON: begin
                if (accept_s && req_off) begin
                    state_nx = ST_CLK_OFF;
                end else if (accept_s) begin
                    ack_nx = 1'b1;
                end else begin
                    state_nx = ST_ON;
                end
            end
            ST_CLK_OFF: state_nx = ST_ISO;
            ST_ISO: begin
                state_nx = ST_SAVE;
                cnt_nx   = SAVE_LOAD;
            end
            ST_SAVE: begin
                if (cnt_r == 8'd0) begin
                    state_nx = ST_PSW_OFF;
                end else begin
                    cnt_nx = cnt_r - 8'd1;
                end
            end
            ST_PSW_OFF: begin
                if (!pg_sync_r || tmo_hit_s) begin
                    state_nx   = ST_OFF;
                    ack_nx     = 1'b1;
                    ack_err_nx = tmo_hit_s && pg_sync_r;
                end else begin
                    state_nx = ST_PSW_OFF;
                end
            end
            ST_OFF: begin
                if (accept_s && !req_off) begin
                    state_nx = ST_PSW_ON;
                end else if (accept_s) begin
                    ack_nx = 1'b1;
                end else begin
                    state_nx = ST_OFF;
                end
            end
            ST_PSW_ON: begin
                if (pg_sync_r || tmo_hit_s) begin
                    state_nx = ST_SETTLE;
                    cnt_nx   = SETTLE_LOAD;
                end else begin
                    state_nx = ST_PSW_ON;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == 8'd0) begin
                    state_nx = ST_RESTORE;
                    cnt_nx   = SAVE_LOAD;
                end else begin
                    cnt_nx = cnt_r - 8'd1;
                end
            end
            ST_RESTORE: begin
                if (cnt_r == 8'd0) begin
                    state_nx = ST_DEISO;
                end else begin
                    cnt_nx = cnt_r - 8'd1;
                end
            end
            ST_DEISO: state_nx = ST_CLK_ON;
            ST_CLK_ON: begin
                state_nx   = ST_ON;
                ack_nx     = 1'b1;
                ack_err_nx = tmo_err_s;
            end
            default: state_nx = ST_ON;
        endcase
    end

    // Domain controls decoded from the state being entered, so the registered outputs track state_r.
    always_comb begin
        clk_en_nx      = 1'b0;
        iso_en_nx      = 1'b1;
        ret_save_nx    = 1'b0;
        ret_restore_nx = 1'b0;
        pwr_sw_en_nx   = 1'b1;
        busy_nx        = 1'b1;
        case (state_nx)
            ST_ON: begin
                clk_en_nx = 1'b1;
                iso_en_nx = 1'b0;
                busy_nx   = 1'b0;
            end
            ST_CLK_OFF: iso_en_nx = 1'b0;
            ST_SAVE:    ret_save_nx = 1'b1;
            ST_PSW_OFF: pwr_sw_en_nx = 1'b0;
            ST_OFF: begin
                pwr_sw_en_nx = 1'b0;
                busy_nx      = 1'b0;
            end
            ST_RESTORE: ret_restore_nx = 1'b1;
            ST_DEISO:   iso_en_nx = 1'b0;
            ST_CLK_ON: begin
                clk_en_nx = 1'b1;
                iso_en_nx = 1'b0;
            end
            default: busy_nx = 1'b1;
        endcase
        req_ready_nx = !busy_nx && !ack_nx;
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_en      <= 1'b1;
            iso_en      <= 1'b0;
            ret_save    <= 1'b0;
            ret_restore <= 1'b0;
            pwr_sw_en   <= 1'b1;
            busy        <= 1'b0;
            req_ready   <= 1'b1;
            ack_valid   <= 1'b0;
            ack_err     <= 1'b0;
        end else begin
            clk_en      <= clk_en_nx;
            iso_en      <= iso_en_nx;
            ret_save    <= ret_save_nx;
            ret_restore <= ret_restore_nx;
            pwr_sw_en   <= pwr_sw_en_nx;
            busy        <= busy_nx;
            req_ready   <= req_ready_nx;
            ack_valid   <= ack_nx;
            ack_err     <= ack_err_nx;
        end
    end

endmodule

// File: tb/tb_pwr_domain_responder.sv
// Self-checking bench for pwr_domain_responder: per-cycle expected output vectors are queued from the
// sequencing table and popped against the DUT each cycle.
module tb_pwr_domain_responder;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst_n, req_valid, req_off, pwr_good;
    logic       req_ready, ack_valid, ack_err, clk_en, iso_en, ret_save, ret_restore, pwr_sw_en, busy;
    logic [3:0] state_o;
    logic [12:0] obs_s, exp_v;
    logic [12:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    pwr_domain_responder #(.SAVE_CYCLES(4), .SETTLE_CYCLES(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_off(req_off), .req_ready(req_ready),
        .ack_valid(ack_valid), .ack_err(ack_err), .pwr_good(pwr_good), .clk_en(clk_en), .iso_en(iso_en),
        .ret_save(ret_save), .ret_restore(ret_restore), .pwr_sw_en(pwr_sw_en), .state_o(state_o), .busy(busy)
    );

    always #5 clk = ~clk;

    assign obs_s = {clk_en, iso_en, ret_save, ret_restore, pwr_sw_en, ack_valid, ack_err, req_ready, busy, state_o};

    // Expected {clk_en,iso_en,ret_save,ret_restore,pwr_sw_en,ack_valid,ack_err,req_ready,busy,state}
    function automatic logic [12:0] vec(input logic [3:0] st, input logic ack, input logic err);
        logic ce, ie, rs, rr, sw, idle;
        ce = 1'b0; ie = 1'b1; rs = 1'b0; rr = 1'b0; sw = 1'b1;
        case (st)
            4'd0:       begin ce = 1'b1; ie = 1'b0; end
            4'd1:       ie = 1'b0;
            4'd3:       rs = 1'b1;
            4'd4, 4'd5: sw = 1'b0;
            4'd8:       rr = 1'b1;
            4'd9:       ie = 1'b0;
            4'd10:      begin ce = 1'b1; ie = 1'b0; end
            default:    ce = 1'b0;
        endcase
        idle = (st == 4'd0) || (st == 4'd5);
        return {ce, ie, rs, rr, sw, ack, err, idle && !ack, !idle, st};
    endfunction

    task automatic push(input logic [3:0] st, input int n, input logic ack = 1'b0, input logic err = 1'b0);
        repeat (n) exp_q.push_back(vec(st, ack, err));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_off = 1'b0; pwr_good = 1'b1;
        push(4'd0, 2);
        repeat (3) @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (obs_s !== exp_v) begin n_bad++; $display("FAIL reset_held: got %b want %b", obs_s, exp_v); end
        rst_n = 1'b1;
        step();
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (obs_s !== exp_v) begin n_bad++; $display("FAIL reset_release: got %b want %b", obs_s, exp_v); end
    endtask

    // pwr_good drops 3 cycles after pwr_sw_en falls (cycle 7 -> 10)
    task automatic test_power_down();
        req_valid = 1'b1; req_off = 1'b1;
        push(4'd1, 1); push(4'd2, 1); push(4'd3, 4); push(4'd4, 6); push(4'd5, 1, 1'b1); push(4'd5, 1);
        for (int c = 1; c <= 14; c++) begin
            step();
            if (c == 1) req_valid = 1'b0;
            if (c == 10) pwr_good = 1'b0;
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs_s !== exp_v) begin n_bad++; $display("FAIL power_down_c%0d: got %b want %b", c, obs_s, exp_v); end
        end
    endtask

    // pwr_good rises 5 cycles after pwr_sw_en rises (cycle 1 -> 6)
    task automatic test_power_up();
        req_valid = 1'b1; req_off = 1'b0;
        push(4'd6, 8); push(4'd7, 8); push(4'd8, 4); push(4'd9, 1); push(4'd10, 1);
        push(4'd0, 1, 1'b1); push(4'd0, 1);
        for (int c = 1; c <= 24; c++) begin
            step();
            if (c == 1) req_valid = 1'b0;
            if (c == 6) pwr_good = 1'b1;
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs_s !== exp_v) begin n_bad++; $display("FAIL power_up_c%0d: got %b want %b", c, obs_s, exp_v); end
        end
    endtask

    task automatic test_redundant();
        req_valid = 1'b1; req_off = 1'b0;
        push(4'd0, 1, 1'b1); push(4'd0, 1);
        for (int c = 1; c <= 2; c++) begin
            step();
            if (c == 1) req_valid = 1'b0;
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs_s !== exp_v) begin n_bad++; $display("FAIL redundant_c%0d: got %b want %b", c, obs_s, exp_v); end
        end
    endtask

    // req_valid held high; a power-up request waits behind the power-down
    task automatic test_back_to_back();
        req_valid = 1'b1; req_off = 1'b1;
        push(4'd1, 1); push(4'd2, 1); push(4'd3, 4); push(4'd4, 3); push(4'd5, 1, 1'b1); push(4'd5, 1);
        push(4'd6, 3); push(4'd7, 8); push(4'd8, 4); push(4'd9, 1); push(4'd10, 1);
        push(4'd0, 1, 1'b1); push(4'd0, 1);
        for (int c = 1; c <= 30; c++) begin
            step();
            if (c == 1) req_off = 1'b0;
            if (c == 7) pwr_good = 1'b0;
            if (c == 12) begin req_valid = 1'b0; pwr_good = 1'b1; end
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs_s !== exp_v) begin n_bad++; $display("FAIL back_to_back_c%0d: got %b want %b", c, obs_s, exp_v); end
        end
    endtask

    task automatic test_reset_mid_save();
        req_valid = 1'b1; req_off = 1'b1;
        push(4'd1, 1); push(4'd2, 1); push(4'd3, 2); push(4'd0, 2);
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 1) req_valid = 1'b0;
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs_s !== exp_v) begin n_bad++; $display("FAIL mid_save_c%0d: got %b want %b", c, obs_s, exp_v); end
        end
        rst_n = 1'b0;
        #1;
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (obs_s !== exp_v) begin n_bad++; $display("FAIL mid_save_reset: got %b want %b", obs_s, exp_v); end
        step();
        rst_n = 1'b1;
        step();
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (obs_s !== exp_v) begin n_bad++; $display("FAIL mid_save_after: got %b want %b", obs_s, exp_v); end
    endtask

    // pwr_good stuck high during power-down
    task automatic test_timeout();
        int acks;
        req_valid = 1'b1; req_off = 1'b1;
`ifdef PWR_DOMAIN_RESPONDER_TIMEOUT_EN
        push(4'd1, 1); push(4'd2, 1); push(4'd3, 4); push(4'd4, TMO); push(4'd5, 1, 1'b1, 1'b1); push(4'd5, 1);
        for (int c = 1; c <= TMO + 8; c++) begin
            step();
            if (c == 1) req_valid = 1'b0;
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs_s !== exp_v) begin n_bad++; $display("FAIL timeout_c%0d: got %b want %b", c, obs_s, exp_v); end
        end
`else
        acks = 0;
        for (int c = 1; c <= 2000; c++) begin
            step();
            if (c == 1) req_valid = 1'b0;
            if (ack_valid === 1'b1) acks++;
        end
        n_cmp++;
        if (acks != 0) begin n_bad++; $display("FAIL no_timeout_ack: got %0d acks want 0", acks); end
        n_cmp++;
        if (state_o !== 4'd4) begin n_bad++; $display("FAIL no_timeout_state: got %0d want 4", state_o); end
`endif
    endtask

    initial begin
        test_reset();
        test_power_down();
        test_power_up();
        test_redundant();
        test_back_to_back();
        test_reset_mid_save();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwr_domain_responder.md
Name: pwr_domain_responder

Overview:
- Responder end of the power-request handshake. It receives power-down and power-up requests from a power-management initiator.
- It sequences the domain's controls in a fixed order: clock enable, isolation, retention save/restore, power switch.
- It returns one acknowledge per accepted request.
- It sits beside each switchable domain, for example one built with optimize_power, and its outputs drive that domain's gating cells.

Parameters:
- SAVE_CYCLES, 4: cycles ret_save / ret_restore stay asserted; legal range 1..255.
- SETTLE_CYCLES, 8: cycles waited after pwr_good rises before restore begins; legal range 1..255.
- TIMEOUT_CYCLES, 1024: cycles waited for a pwr_good transition; used only with the optional feature; legal range 2..65535.

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  initiator presents a request
- req_off  in  1  request type: 1 = power down, 0 = power up; valid with req_valid
- req_ready  out  1  responder can accept a request
- ack_valid  out  1  one-cycle acknowledge of completion
- ack_err  out  1  completion error flag; valid with ack_valid
- pwr_good  in  1  power-switch status from the domain; asynchronous, double-flopped internally
- clk_en  out  1  domain clock-gate enable
- iso_en  out  1  isolation clamp enable
- ret_save  out  1  retention save strobe
- ret_restore  out  1  retention restore strobe
- pwr_sw_en  out  1  power-switch enable
- state_o  out  4  current FSM state encoding, for debug
- busy  out  1  high in every state except ON and OFF

Behaviour:
- Reset (async assert, sync deassert):
  - State ON.
  - clk_en=1, pwr_sw_en=1, iso_en=0, ret_save=0, ret_restore=0.
  - ack_valid=0, ack_err=0, req_ready=1, busy=0, all counters 0.
- State encodings: ON=0, CLK_OFF=1, ISO=2, SAVE=3, PSW_OFF=4, OFF=5, PSW_ON=6, SETTLE=7, RESTORE=8, DEISO=9, CLK_ON=10.
- Handshake:
  - req_ready = (state is ON or OFF) and not ack_valid.
  - A request is accepted on a cycle where req_valid and req_ready are both high; req_off is sampled on that cycle.
  - req_valid while busy is held off (req_ready low); no request is dropped or queued.
- Power-down from ON:
  - CLK_OFF: clk_en=0 for 1 cycle.
  - ISO: iso_en=1 for 1 cycle.
  - SAVE: ret_save=1 for exactly SAVE_CYCLES cycles.
  - PSW_OFF: pwr_sw_en=0; wait until synchronised pwr_good=0.
  - Then OFF, with ack_valid=1 for 1 cycle.
  - iso_en stays 1 and clk_en stays 0 in OFF.
- Power-up from OFF:
  - PSW_ON: pwr_sw_en=1; wait until synchronised pwr_good=1.
  - SETTLE: SETTLE_CYCLES cycles.
  - RESTORE: ret_restore=1 for SAVE_CYCLES cycles.
  - DEISO: iso_en=0 for 1 cycle.
  - CLK_ON: clk_en=1 for 1 cycle.
  - Then ON, with ack_valid pulse.
- Redundant request (off while ON→off already done, i.e. power-down in OFF, or power-up in ON):
  - Accepted; ack_valid pulses on the next cycle.
  - No output change; ack_err=0.
- Latency, acceptance to ack, with 2-cycle synchroniser delay:
  - Power-down = 3 + SAVE_CYCLES + sync delay + 1 cycles.
  - Default, pwr_good drops immediately: 10 cycles.
- All outputs are registered. ret_save and ret_restore are never both high. iso_en is never 0 while pwr_sw_en=0.
- Counters are 8 bits and load at state entry.
- pwr_good glitches in non-wait states are ignored.
- Reset asserted mid-sequence: outputs return immediately to reset values; the domain is assumed re-powered by the system reset.

Optional Feature:
- Macro: PWR_DOMAIN_RESPONDER_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs in PSW_OFF and PSW_ON.
  - If pwr_good has not reached the expected level after TIMEOUT_CYCLES cycles, the FSM advances as if it had.
  - The completing ack then carries ack_err=1.
- Undefined:
  - The FSM waits indefinitely.
  - ack_err is tied to 0, and no timeout counter is synthesised.

Test Plan:
1. Reset, then power-down request with pwr_good dropping 3 cycles after pwr_sw_en falls → clk_en, iso_en, ret_save (4 cycles), pwr_sw_en transition in that order; ack_valid exactly 1 cycle; final OFF (state_o=5), iso_en=1, clk_en=0.
2. From OFF, power-up with pwr_good rising after 5 cycles → 8 settle cycles, ret_restore high 4 cycles, then iso_en=0, then clk_en=1; ack; state_o=0.
3. Redundant power-up in ON → ack_valid on the next cycle, no output toggles, ack_err=0.
4. req_valid held high through a power-down sequence with a second request queued → req_ready stays 0 until after ack; second request accepted exactly 1 cycle after the ack cycle.
5. rst_n asserted during SAVE (cycle 2 of 4) → immediately clk_en=1, iso_en=0, ret_save=0, pwr_sw_en=1, state_o=0.
6. With PWR_DOMAIN_RESPONDER_TIMEOUT_EN and TIMEOUT_CYCLES=16, pwr_good stuck at 1 during power-down → ack at timeout with ack_err=1, state OFF; without the macro → no ack after 2000 cycles.
